// File: rtl/mod_updn_counter.sv
// mod_updn_counter: cascadable NDIG-digit up/down counter, each digit modulo MOD.
// Supports synchronous clear and load (out-of-range load fields clamp to MOD-1),
// wrap or saturate mode, and a sticky saturation flag. Carry/borrow ripples
// through all digits within one cycle.
//
// Ports:
//   clk       rising-edge clock
//   n_rst     asynchronous active-low reset
//   cin       count enable / carry-in from upstream stage
//   up1_dn0   direction: 1 = increment, 0 = decrement
//   sat       mode: 1 = saturate at limit, 0 = wrap
//   clr       synchronous clear (highest priority)
//   ld        synchronous load of ld_val
//   ld_val    load value, one DW-bit field per digit
//   cnt       registered count, digit 0 in cnt[DW-1:0]
//   co        combinational carry/borrow out to downstream stage
//   sat_flag  registered sticky saturation indicator
//
// Optional feature, macro UPDN_CNT_MATCH_EN:
//   match_val input compare value; match is a registered flag that is high
//   exactly in the cycles where cnt == match_val.
module mod_updn_counter #(
  parameter int unsigned DW   = 4,
  parameter int unsigned NDIG = 2,
  parameter int unsigned MOD  = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 cin,
  input  logic                 up1_dn0,
  input  logic                 sat,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [NDIG*DW-1:0]   ld_val,
`ifdef UPDN_CNT_MATCH_EN
  input  logic [NDIG*DW-1:0]   match_val,
  output logic                 match,
`endif
  output logic [NDIG*DW-1:0]   cnt,
  output logic                 co,
  output logic                 sat_flag
);

  localparam int unsigned CW = NDIG * DW;
  // Modulus widened by one bit so MOD = 2^DW is representable.
  localparam logic [DW:0]   MOD_W = (DW+1)'(MOD);
  localparam logic [DW-1:0] DMAX  = DW'(MOD - 1);

  logic          all_max;
  logic          all_zero;
  logic          at_limit;
  logic [CW-1:0] step_val;
  logic [CW-1:0] ld_clamped;
  logic [CW-1:0] cnt_nxt;
  logic          sat_flag_nxt;
  logic [DW-1:0] s_dig;
  logic [DW-1:0] l_dig;
  logic          carry;

  // Limit detection: every digit at MOD-1, or every digit at 0.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cnt[i*DW +: DW] != DMAX) all_max  = 1'b0;
      if (cnt[i*DW +: DW] != '0)   all_zero = 1'b0;
    end
  end

  assign at_limit = up1_dn0 ? all_max : all_zero;

  // +/-1 in base MOD; carry/borrow ripples from digit 0 upward.
  always_comb begin
    step_val = cnt;
    carry    = 1'b1;
    s_dig    = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      s_dig = cnt[i*DW +: DW];
      if (carry) begin
        if (up1_dn0) begin
          if (s_dig == DMAX) begin
            step_val[i*DW +: DW] = '0;
          end else begin
            step_val[i*DW +: DW] = s_dig + DW'(1);
            carry = 1'b0;
          end
        end else begin
          if (s_dig == '0) begin
            step_val[i*DW +: DW] = DMAX;
          end else begin
            step_val[i*DW +: DW] = s_dig - DW'(1);
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Load fields outside 0..MOD-1 clamp to MOD-1 so illegal digits never appear.
  always_comb begin
    ld_clamped = ld_val;
    l_dig      = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      l_dig = ld_val[i*DW +: DW];
      if ({1'b0, l_dig} >= MOD_W) ld_clamped[i*DW +: DW] = DMAX;
    end
  end

  // Next state: clr > ld > count > hold.
  always_comb begin
    cnt_nxt      = cnt;
    sat_flag_nxt = sat_flag;
    if (clr) begin
      cnt_nxt      = '0;
      sat_flag_nxt = 1'b0;
    end else if (ld) begin
      cnt_nxt      = ld_clamped;
      sat_flag_nxt = 1'b0;
    end else if (cin) begin
      if (sat && at_limit) begin
        sat_flag_nxt = 1'b1;
      end else begin
        cnt_nxt = step_val;
      end
    end
  end

  // Downstream carry only when this stage actually wraps.
  assign co = cin & ~clr & ~ld & ~sat & at_limit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      sat_flag <= sat_flag_nxt;
    end
  end

`ifdef UPDN_CNT_MATCH_EN
  // Compare against the next count so match lines up with cnt.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      match <= 1'b0;
    end else begin
      match <= (cnt_nxt == match_val);
    end
  end
`endif

endmodule

// File: tb/tb_mod_updn_counter.sv
// Scoreboard bench for mod_updn_counter (DW=4, NDIG=2, MOD=10, BCD values).
// The driver pushes the hand-computed expected outputs for each driven cycle;
// a monitor pops and compares them on the falling edge.
module tb_mod_updn_counter;

  logic       clk;
  logic       n_rst;
  logic       cin;
  logic       up1_dn0;
  logic       sat;
  logic       clr;
  logic       ld;
  logic [7:0] ld_val;
  logic [7:0] cnt;
  logic       co;
  logic       sat_flag;
`ifdef UPDN_CNT_MATCH_EN
  logic [7:0] match_val;
  logic       match;
`endif

  typedef struct packed {
    logic [7:0] cnt;
    logic       co;
    logic       sf;
    logic       m;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec;
  int    n_err;

  mod_updn_counter #(.DW(4), .NDIG(2), .MOD(10)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cin      (cin),
    .up1_dn0  (up1_dn0),
    .sat      (sat),
    .clr      (clr),
    .ld       (ld),
    .ld_val   (ld_val),
`ifdef UPDN_CNT_MATCH_EN
    .match_val(match_val),
    .match    (match),
`endif
    .cnt      (cnt),
    .co       (co),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] ec, input logic eco, input logic esf, input string nm);
    exp_t e;
    e.cnt = ec;
    e.co  = eco;
    e.sf  = esf;
    e.m   = (ec == 8'h05);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive one cycle, record what cnt/co/sat_flag must show during it, advance.
  task automatic cyc(input logic c, input logic u, input logic s, input logic cl,
                     input logic l, input logic [7:0] lv,
                     input logic [7:0] ec, input logic eco, input logic esf,
                     input string nm);
    cin = c; up1_dn0 = u; sat = s; clr = cl; ld = l; ld_val = lv;
    push(ec, eco, esf, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare one expectation per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g.cnt = cnt;
      g.co  = co;
      g.sf  = sat_flag;
`ifdef UPDN_CNT_MATCH_EN
      g.m   = match;
`else
      g.m   = e.m;
`endif
      n_vec = n_vec + 1;
      if (g !== e) begin
        n_err = n_err + 1;
        $display("FAIL %s: got cnt=%h co=%b sat_flag=%b match=%b, expected cnt=%h co=%b sat_flag=%b match=%b",
                 nm, g.cnt, g.co, g.sf, g.m, e.cnt, e.co, e.sf, e.m);
      end
    end
  end

  initial begin
    clk = 1'b0; n_rst = 1'b0;
    cin = 1'b0; up1_dn0 = 1'b1; sat = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = 8'h00;
    n_vec = 0; n_err = 0;
`ifdef UPDN_CNT_MATCH_EN
    match_val = 8'h05;
`endif
    push(8'h00, 1'b0, 1'b0, "reset");
    #22;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Count up
    cyc(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, "rst_release");
    run(11);
    cyc(1, 1, 0, 0, 0, 8'h00, 8'h12, 0, 0, "up_12");
    run(8);
    // Up-wrap and co
    cyc(1, 1, 0, 0, 1, 8'h98, 8'h21, 0, 0, "up_21_ld_blocks_co");
    cyc(1, 1, 0, 0, 0, 8'h00, 8'h98, 0, 0, "ld_98");
    cyc(1, 1, 0, 0, 0, 8'h00, 8'h99, 1, 0, "upwrap_co");
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, "wrapped_00");
    cyc(0, 1, 0, 0, 1, 8'h99, 8'h00, 0, 0, "ld_99");
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h99, 0, 0, "cin0_no_co");
    // Down-wrap and inner borrow
    cyc(0, 1, 0, 0, 1, 8'h01, 8'h99, 0, 0, "cin0_hold_99");
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, "dn_01");
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, "dnwrap_co");
    cyc(0, 0, 0, 0, 1, 8'h10, 8'h99, 0, 0, "dnwrap_99");
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0, "dn_10");
    cyc(0, 0, 0, 0, 0, 8'h00, 8'h09, 0, 0, "inner_borrow_09");
    // Saturation up
    cyc(0, 1, 1, 0, 1, 8'h98, 8'h09, 0, 0, "ld_98_sat");
    cyc(1, 1, 1, 0, 0, 8'h00, 8'h98, 0, 0, "sat_98");
    cyc(1, 1, 1, 0, 0, 8'h00, 8'h99, 0, 0, "sat_99_co0");
    cyc(1, 1, 1, 0, 0, 8'h00, 8'h99, 0, 1, "sat_hold1");
    cyc(1, 1, 1, 0, 0, 8'h00, 8'h99, 0, 1, "sat_hold2");
    cyc(1, 0, 1, 0, 0, 8'h00, 8'h99, 0, 1, "sat_hold3");
    cyc(0, 0, 1, 0, 0, 8'h00, 8'h98, 0, 1, "dn_flag_sticky");
    cyc(0, 0, 0, 0, 0, 8'h00, 8'h98, 0, 1, "flag_sticky_sat0");
    cyc(1, 0, 0, 1, 0, 8'h00, 8'h98, 0, 1, "clr_cycle");
    cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, "after_clr");
    // Priority and clamp
    cyc(0, 1, 0, 0, 1, 8'h55, 8'h00, 0, 0, "ld_55_pre");
    cyc(0, 1, 0, 1, 1, 8'h77, 8'h55, 0, 0, "ld_55");
    cyc(0, 1, 0, 0, 1, 8'hAF, 8'h00, 0, 0, "clr_over_ld");
    cyc(0, 1, 0, 0, 1, 8'h3C, 8'h99, 0, 0, "clamp_AF");
    cyc(0, 1, 0, 0, 1, 8'h00, 8'h39, 0, 0, "clamp_3C");
    // Saturation down
    cyc(1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, "sat_dn_limit_co0");
    cyc(0, 0, 1, 0, 1, 8'h42, 8'h00, 0, 1, "sat_dn_flag");
    cyc(1, 1, 0, 0, 0, 8'h00, 8'h42, 0, 0, "ld_clears_flag");
    cyc(1, 1, 0, 0, 0, 8'h00, 8'h43, 0, 0, "count_43");
    // Async reset between edges (cnt is 0x44 before it)
    #2;
    n_rst = 1'b0;
    cin = 1'b0;
    push(8'h00, 1'b0, 1'b0, "async_rst");
    @(posedge clk);
    #1;
    push(8'h00, 1'b0, 1'b0, "in_reset_hold");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    // Count 00..06 after reset; match high only at 05
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 0, 0, 0, 8'h00, 8'(i), 0, 0, "match_walk");
    end
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h07, 0, 0, "walk_end");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
